// File: rtl/accl_tilt_filter.sv
// Resamples the held accelerometer X/Y words on a fixed tick and runs a per-axis moving average.
// Hysteretic tilt flags {up, down, left, right} are derived from the averages.
module accl_tilt_filter #(
    parameter int SAMPLE_DIV = 40000,
    parameter int AVG_LOG2   = 3,
    parameter int TH_ON      = 64,
    parameter int TH_OFF     = 48
) (
    input  logic               iSPI_CLK,
    input  logic               iRSTN,
    input  logic [7:0]         iDATA_X_L,
    input  logic [7:0]         iDATA_X_H,
    input  logic [7:0]         iDATA_Y_L,
    input  logic [7:0]         iDATA_Y_H,
    input  logic               iENABLE,
    output logic signed [15:0] oX_AVG,
    output logic signed [15:0] oY_AVG,
    output logic               oVALID,
    output logic               oPRIMED,
    output logic [3:0]         oTILT
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 16 + AVG_LOG2;
    localparam int CW    = $clog2(SAMPLE_DIV);

    localparam logic [CW-1:0]       CNT_LAST  = CW'(SAMPLE_DIV - 1);
    localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic signed [15:0]  ON_POS    = 16'(TH_ON);
    localparam logic signed [15:0]  OFF_POS   = 16'(TH_OFF);
    localparam logic signed [15:0]  ON_NEG    = 16'(-TH_ON);
    localparam logic signed [15:0]  OFF_NEG   = 16'(-TH_OFF);

    typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE, OUTPUT} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         tick_cnt;
    logic                  tick;
    logic signed [15:0]    cap_x;
    logic signed [15:0]    cap_y;
    logic signed [15:0]    win_x [DEPTH];
    logic signed [15:0]    win_y [DEPTH];
    logic [AVG_LOG2-1:0]   wptr;
    logic [AVG_LOG2:0]     fill;
    logic signed [SW-1:0]  sum_x;
    logic signed [SW-1:0]  sum_y;
    logic signed [SW-1:0]  shift_x;
    logic signed [SW-1:0]  shift_y;
    logic signed [15:0]    avg_x;
    logic signed [15:0]    avg_y;
    logic [3:0]            tilt_next;

    function automatic logic signed [SW-1:0] sext(input logic signed [15:0] v);
        return {{AVG_LOG2{v[15]}}, v};
    endfunction

    assign tick = iENABLE && (tick_cnt == CNT_LAST);

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            tick_cnt <= '0;
        end else if (!iENABLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = CAPTURE;
            CAPTURE: state_next = UPDATE;
            UPDATE:  state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Running sums drop the oldest entry and add the newest, so the average stays exact.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            cap_x <= '0;
            cap_y <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                win_x[i] <= '0;
                win_y[i] <= '0;
            end
            wptr  <= '0;
            fill  <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else begin
            if (state == CAPTURE) begin
                cap_x <= {iDATA_X_H, iDATA_X_L};
                cap_y <= {iDATA_Y_H, iDATA_Y_L};
            end
            if (state == UPDATE) begin
                sum_x       <= sum_x - sext(win_x[wptr]) + sext(cap_x);
                sum_y       <= sum_y - sext(win_y[wptr]) + sext(cap_y);
                win_x[wptr] <= cap_x;
                win_y[wptr] <= cap_y;
                wptr        <= wptr + 1'b1;
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    assign shift_x = sum_x >>> AVG_LOG2;
    assign shift_y = sum_y >>> AVG_LOG2;
    assign avg_x   = shift_x[15:0];
    assign avg_y   = shift_y[15:0];

    // Values landing exactly on a threshold fall through both tests and hold the flag.
    always_comb begin
        tilt_next = oTILT;
        if (avg_x > ON_POS)       tilt_next[0] = 1'b1;
        else if (avg_x < OFF_POS) tilt_next[0] = 1'b0;
        if (avg_x < ON_NEG)       tilt_next[1] = 1'b1;
        else if (avg_x > OFF_NEG) tilt_next[1] = 1'b0;
        if (avg_y < ON_NEG)       tilt_next[2] = 1'b1;
        else if (avg_y > OFF_NEG) tilt_next[2] = 1'b0;
        if (avg_y > ON_POS)       tilt_next[3] = 1'b1;
        else if (avg_y < OFF_POS) tilt_next[3] = 1'b0;
    end

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oX_AVG  <= '0;
            oY_AVG  <= '0;
            oVALID  <= 1'b0;
            oPRIMED <= 1'b0;
            oTILT   <= '0;
        end else begin
            oVALID <= (state == OUTPUT);
            if (state == OUTPUT) begin
                oX_AVG  <= avg_x;
                oY_AVG  <= avg_y;
                oTILT   <= tilt_next;
                oPRIMED <= (fill == FILL_FULL);
            end
        end
    end

endmodule
